// File: rtl/rsb_pkg.sv
// Shared constants and register-width bookkeeping for the pipelined
// ripple-borrow subtractor.
package rsb_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int BPS_DEF   = 2;
    localparam int N_DEF     = WIDTH_DEF / BPS_DEF;

    // Width of the register after stage k (k=0 is the input register):
    // valid + borrow + k*bps resolved diff bits + both unconsumed operand slices.
    function automatic int stage_width(input int width, input int bps, input int k);
        return width * 2 + 2 - bps * k;
    endfunction

endpackage

// File: rtl/rsb_slice.sv
// Combinational BPS-bit ripple-borrow slice: d = x - y - br_in over BPS bits.
module rsb_slice
    import rsb_pkg::*;
#(
    parameter int BPS = BPS_DEF
) (
    input  logic [BPS-1:0] x,
    input  logic [BPS-1:0] y,
    input  logic           br_in,
    output logic [BPS-1:0] d,
    output logic           br_out
);

    logic br;

    // NOTE: blocking assignments here let br ripple bit to bit within one
    // evaluation; every variable gets a value first so no latch is inferred.
    always_comb begin
        br = br_in;
        d  = '0;
        for (int i = 0; i < BPS; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        br_out = br;
    end

endmodule

// File: rtl/rsb_pipe_2bit.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin, BPS bits per stage,
// with valid tracking, a global stall enable and synchronous reset.
module rsb_pipe_2bit
    import rsb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BPS   = BPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N = WIDTH / BPS;

    logic             ir_v;
    logic             ir_br;
    logic [WIDTH-1:0] ir_a;
    logic [WIDTH-1:0] ir_b;

    // NOTE: reset is sampled on the clock edge and takes priority over en,
    // so a stalled pipeline still flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_v  <= 1'b0;
            ir_br <= 1'b0;
            ir_a  <= '0;
            ir_b  <= '0;
        end else if (en) begin
            ir_v  <= in_valid;
            ir_br <= bin;
            ir_a  <= a;
            ir_b  <= b;
        end
    end

    for (genvar k = 1; k <= N; k++) begin : g_stg
        localparam int SW = stage_width(WIDTH, BPS, k);
        localparam int DW = BPS * k;
        localparam int RW = (SW - 2 - DW) / 2;  // operand bits left for later stages
        localparam int IW = RW + BPS;           // operand bits arriving at this stage

        logic           src_v;
        logic           src_br;
        logic [IW-1:0]  src_a;
        logic [IW-1:0]  src_b;
        logic [BPS-1:0] d_new;
        logic           br_new;
        logic [DW-1:0]  d_nxt;
        logic           v_q;
        logic           br_q;
        logic [DW-1:0]  d_q;

        if (k == 1) begin : g_src
            assign src_v  = ir_v;
            assign src_br = ir_br;
            assign src_a  = ir_a;
            assign src_b  = ir_b;
            assign d_nxt  = d_new;
        end else begin : g_src
            assign src_v  = g_stg[k-1].v_q;
            assign src_br = g_stg[k-1].br_q;
            assign src_a  = g_stg[k-1].g_rem.a_q;
            assign src_b  = g_stg[k-1].g_rem.b_q;
            assign d_nxt  = {d_new, g_stg[k-1].d_q};
        end

        rsb_slice #(.BPS(BPS)) u_slice (
            .x      (src_a[BPS-1:0]),
            .y      (src_b[BPS-1:0]),
            .br_in  (src_br),
            .d      (d_new),
            .br_out (br_new)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                br_q <= 1'b0;
                d_q  <= '0;
            end else if (en) begin
                v_q  <= src_v;
                br_q <= br_new;
                d_q  <= d_nxt;
            end
        end

        // The last stage has no operand bits left to carry forward.
        if (k < N) begin : g_rem
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= src_a[IW-1:BPS];
                    b_q <= src_b[IW-1:BPS];
                end
            end
        end
    end

    assign out_valid = g_stg[N].v_q;
    assign diff      = g_stg[N].d_q;
    assign bout      = g_stg[N].br_q;

endmodule
